mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, RAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter STARVE_MAX, default 4, the number of consecutive lost arbitrations after which the instruction port wins.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port nRST, input, 1, asynchronous active-low reset.
REQ-006 SHALL have instruction-port inputs i_req (1) and i_addr (ADDR_W), and outputs i_rdata (DATA_W) and i_ready (1); this port is read-only.
REQ-007 SHALL have data-port inputs d_req (1), d_wen (1), d_addr (ADDR_W) and d_wdata (DATA_W), and outputs d_rdata (DATA_W) and d_ready (1).
REQ-008 SHALL have FPGA-port inputs f_req (1), f_wen (1), f_addr (ADDR_W) and f_wdata (DATA_W), and output f_ready (1).
REQ-009 SHALL have RAM-side outputs ram_addr (ADDR_W), ram_wen (1) and ram_wdata (DATA_W), and inputs ram_rdata (DATA_W) and ram_busy (1).
REQ-010 SHALL have output grant (2): 0 none, 1 instruction, 2 data, 3 FPGA.

Function
REQ-011 SHALL implement FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
REQ-012 SHALL, in IDLE with any request high, select a winner and capture its addr, wen and wdata into internal registers; it SHALL move to ISSUE on the next edge.
REQ-013 SHALL, in IDLE with no request, stay in IDLE and hold grant = 0.
REQ-014 SHALL resolve priority as FPGA > data > instruction.
REQ-015 SHALL override REQ-014 and grant the instruction port when its starvation counter equals STARVE_MAX.
REQ-016 SHALL increment the starvation counter each time i_req is high at arbitration and instruction loses, saturating at STARVE_MAX.
REQ-017 SHALL clear the starvation counter when instruction is granted or i_req is low at arbitration.
REQ-018 SHALL drive ram_addr and ram_wdata from the captured registers in ISSUE, WAIT and RESP.
REQ-019 SHALL assert ram_wen only during the single ISSUE cycle, and only for a captured write.
REQ-020 SHALL move from ISSUE to WAIT unconditionally.
REQ-021 SHALL stay in WAIT while ram_busy = 1.
REQ-022 SHALL, when ram_busy = 0 in WAIT, load ram_rdata into the granted port's rdata register (reads only) and enter RESP.
REQ-023 SHALL pulse the granted port's ready for exactly the RESP cycle, then return to IDLE.
REQ-024 SHALL give a minimum latency of 3 cycles from request sampled in IDLE to ready high.
REQ-025 SHALL hold i_rdata and d_rdata stable until the next completed read on that port.
REQ-026 SHALL complete a transaction even if its req drops after capture; ready still pulses.
REQ-027 SHALL consider requests raised outside IDLE only at the next IDLE.
REQ-028 SHALL treat a data write as a write: d_rdata unchanged, d_ready pulses.
REQ-029 SHALL hold grant at the captured owner from ISSUE through RESP.

Reset
REQ-030 SHALL, on nRST low, asynchronously force state IDLE and grant = 0.
REQ-031 SHALL, on nRST low, force ram_wen, i_ready, d_ready and f_ready to 0.
REQ-032 SHALL, on nRST low, clear i_rdata, d_rdata, ram_addr, ram_wdata, the captured registers and the starvation counter to 0.
REQ-033 SHALL abandon any in-flight transaction on reset mid-operation, with no ready pulse afterwards.

Configuration
REQ-034 SHALL compile the FPGA port in when macro MEM_ARBITER_FPGA_PORT_EN is defined; that port then participates at top priority.
REQ-035 SHALL, without MEM_ARBITER_FPGA_PORT_EN, keep the FPGA ports present but ignore f_req, never issue grant = 3, and tie f_ready to 0.

Structure
REQ-036 SHALL take state_t, grant_t (NONE/INSTR/DATA/FPGA) and default widths from shared package mem_arb_pkg.
REQ-037 SHALL contain one sub-module, mem_arb_prio, which is combinational: winner select plus starvation override.

Verification
REQ-038 SHALL cover: d_req=1, d_wen=0, d_addr=0x010, ram_busy low, ram_rdata=0x12345678 -> d_ready high 3 cycles later, d_rdata=0x12345678.
REQ-039 SHALL cover: i_req, d_req and f_req (f_wen=1, f_addr=0x0FF, f_wdata=0xA5A5A5A5) asserted together -> grant=3, one ram_wen pulse to 0x0FF, then data, then instruction served.
REQ-040 SHALL cover: i_req and d_req held continuously, STARVE_MAX=4 -> instruction granted on the 5th arbitration.
REQ-041 SHALL cover: ram_busy held 7 cycles in WAIT -> ready delayed to 7 cycles plus minimum, with ram_wen high only once.
REQ-042 SHALL cover: nRST pulsed low during WAIT -> immediate IDLE, grant=0, no ready pulse; the next request is served normally.
REQ-043 SHALL cover: build without MEM_ARBITER_FPGA_PORT_EN, f_req=1 alone -> grant stays 0, f_ready stays 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the three-port RAM arbiter.
package mem_arb_pkg;

  localparam int DEF_ADDR_W     = 12;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_STARVE_MAX = 4;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ISSUE = 2'd1;
  localparam state_t ST_WAIT  = 2'd2;
  localparam state_t ST_RESP  = 2'd3;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    INSTR = 2'd1,
    DATA  = 2'd2,
    FPGA  = 2'd3
  } grant_t;

endpackage

// File: rtl/mem_arb_prio.sv
// Combinational winner select: FPGA > data > instruction, unless the
// instruction port has been starved long enough to force its turn.
module mem_arb_prio
  import mem_arb_pkg::*;
(
  input  logic   i_ireq,
  input  logic   i_dreq,
  input  logic   i_freq,
  input  logic   i_starved,
  output grant_t o_winner
);

  // Starvation override sits above the fixed priority order.
  always_comb begin
    o_winner = NONE;
    if (i_ireq && i_starved) begin
      o_winner = INSTR;
    end else if (i_freq) begin
      o_winner = FPGA;
    end else if (i_dreq) begin
      o_winner = DATA;
    end else if (i_ireq) begin
      o_winner = INSTR;
    end else begin
      o_winner = NONE;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Three-port single-RAM arbiter (IDLE -> ISSUE -> WAIT -> RESP).
// Define MEM_ARBITER_FPGA_PORT_EN to let the FPGA port take part in arbitration.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_req,
  input  logic              d_wen,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  input  logic              f_req,
  input  logic              f_wen,
  input  logic [ADDR_W-1:0] f_addr,
  input  logic [DATA_W-1:0] f_wdata,
  output logic              f_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wen,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_busy,
  output logic [1:0]        grant
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  state_t            r_state;
  grant_t            r_grant;
  logic [ADDR_W-1:0] r_addr;
  logic              r_wen;
  logic [DATA_W-1:0] r_wdata;
  logic              r_ram_wen;
  logic [DATA_W-1:0] r_i_rdata;
  logic [DATA_W-1:0] r_d_rdata;
  logic              r_i_ready;
  logic              r_d_ready;
  logic [CNT_W-1:0]  r_starve;

  logic              w_f_req;
  logic              w_any_req;
  logic              w_starved;
  grant_t            w_winner;
  logic [ADDR_W-1:0] w_sel_addr;
  logic              w_sel_wen;
  logic [DATA_W-1:0] w_sel_wdata;

`ifdef MEM_ARBITER_FPGA_PORT_EN
  logic r_f_ready;
  assign w_f_req = f_req;
  assign f_ready = r_f_ready;
`else
  logic w_unused_f_req;
  assign w_unused_f_req = f_req;
  assign w_f_req        = 1'b0;
  assign f_ready        = 1'b0;
`endif

  assign w_any_req = i_req | d_req | w_f_req;
  assign w_starved = (r_starve == CNT_W'(STARVE_MAX));

  mem_arb_prio u_prio (
    .i_ireq    (i_req),
    .i_dreq    (d_req),
    .i_freq    (w_f_req),
    .i_starved (w_starved),
    .o_winner  (w_winner)
  );

  // Route the winning port's request fields to the capture registers.
  always_comb begin
    w_sel_addr  = i_addr;
    w_sel_wen   = 1'b0;
    w_sel_wdata = {DATA_W{1'b0}};
    case (w_winner)
      FPGA: begin
        w_sel_addr  = f_addr;
        w_sel_wen   = f_wen;
        w_sel_wdata = f_wdata;
      end
      DATA: begin
        w_sel_addr  = d_addr;
        w_sel_wen   = d_wen;
        w_sel_wdata = d_wdata;
      end
      default: begin
        w_sel_addr  = i_addr;
        w_sel_wen   = 1'b0;
        w_sel_wdata = {DATA_W{1'b0}};
      end
    endcase
  end

  // Transaction FSM; ram_wen and the ready pulses are one-cycle registers.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_state   <= ST_IDLE;
      r_grant   <= NONE;
      r_addr    <= {ADDR_W{1'b0}};
      r_wen     <= 1'b0;
      r_wdata   <= {DATA_W{1'b0}};
      r_ram_wen <= 1'b0;
      r_i_rdata <= {DATA_W{1'b0}};
      r_d_rdata <= {DATA_W{1'b0}};
      r_i_ready <= 1'b0;
      r_d_ready <= 1'b0;
      r_starve  <= {CNT_W{1'b0}};
`ifdef MEM_ARBITER_FPGA_PORT_EN
      r_f_ready <= 1'b0;
`endif
    end else begin
      r_ram_wen <= 1'b0;
      r_i_ready <= 1'b0;
      r_d_ready <= 1'b0;
`ifdef MEM_ARBITER_FPGA_PORT_EN
      r_f_ready <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_state   <= ST_ISSUE;
            r_grant   <= w_winner;
            r_addr    <= w_sel_addr;
            r_wen     <= w_sel_wen;
            r_wdata   <= w_sel_wdata;
            r_ram_wen <= w_sel_wen;
            if (!i_req || (w_winner == INSTR)) begin
              r_starve <= {CNT_W{1'b0}};
            end else if (!w_starved) begin
              r_starve <= r_starve + CNT_W'(1);
            end
          end else begin
            r_grant <= NONE;
          end
        end
        ST_ISSUE: r_state <= ST_WAIT;
        ST_WAIT: begin
          if (!ram_busy) begin
            r_state <= ST_RESP;
            case (r_grant)
              INSTR: begin
                r_i_rdata <= ram_rdata;
                r_i_ready <= 1'b1;
              end
              DATA: begin
                if (!r_wen) begin
                  r_d_rdata <= ram_rdata;
                end
                r_d_ready <= 1'b1;
              end
`ifdef MEM_ARBITER_FPGA_PORT_EN
              FPGA: r_f_ready <= 1'b1;
`endif
              default: r_state <= ST_RESP;
            endcase
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
          r_grant <= NONE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_grant <= NONE;
        end
      endcase
    end
  end

  assign grant     = r_grant;
  assign ram_addr  = r_addr;
  assign ram_wdata = r_wdata;
  assign ram_wen   = r_ram_wen;
  assign i_rdata   = r_i_rdata;
  assign d_rdata   = r_d_rdata;
  assign i_ready   = r_i_ready;
  assign d_ready   = r_d_ready;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table plus hand-written corner sequences.
module tb_mem_arbiter;

  logic        clk;
  logic        nRST;
  logic        i_req, d_req, d_wen, f_req, f_wen, ram_busy;
  logic [11:0] i_addr, d_addr, f_addr;
  logic [31:0] d_wdata, f_wdata, ram_rdata;
  logic [31:0] i_rdata, d_rdata, ram_wdata;
  logic        i_ready, d_ready, f_ready, ram_wen;
  logic [11:0] ram_addr;
  logic [1:0]  grant;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        ireq;
    logic [11:0] iaddr;
    logic        dreq;
    logic        dwen;
    logic [11:0] daddr;
    logic [31:0] dwdata;
    logic [31:0] rdata;
    logic [1:0]  exp_grant;
    logic        exp_wen;
    logic [11:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [31:0] exp_irdata;
    logic [31:0] exp_drdata;
  } vec_t;

  vec_t vecs [5];

  mem_arbiter dut (
    .clk(clk), .nRST(nRST),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .f_req(f_req), .f_wen(f_wen), .f_addr(f_addr), .f_wdata(f_wdata), .f_ready(f_ready),
    .ram_addr(ram_addr), .ram_wen(ram_wen), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_busy(ram_busy), .grant(grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    total++;
    bad++;
    $display("FAIL %s: timed out", nm);
  endtask

  task automatic wait_grant(input bit want_nz, output logic [1:0] g);
    int n = 0;
    while (((grant != 2'd0) != want_nz) && (n < 20)) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) timeout("wait_grant");
    g = grant;
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    i_req = v.ireq; i_addr = v.iaddr;
    d_req = v.dreq; d_wen = v.dwen; d_addr = v.daddr; d_wdata = v.dwdata;
    ram_rdata = v.rdata; ram_busy = 1'b0;
    @(posedge clk); #1;
    chk("grant", {30'd0, grant}, {30'd0, v.exp_grant});
    chk("ram_wen_issue", {31'd0, ram_wen}, {31'd0, v.exp_wen});
    chk("ram_addr", {20'd0, ram_addr}, {20'd0, v.exp_addr});
    chk("ram_wdata", ram_wdata, v.exp_wdata);
    i_req = 1'b0; d_req = 1'b0; d_wen = 1'b0;
    @(posedge clk); #1;
    chk("ram_wen_wait", {31'd0, ram_wen}, 32'd0);
    chk("grant_hold", {30'd0, grant}, {30'd0, v.exp_grant});
    @(posedge clk); #1;
    chk("i_ready_resp", {31'd0, i_ready}, {31'd0, (v.exp_grant == 2'd1)});
    chk("d_ready_resp", {31'd0, d_ready}, {31'd0, (v.exp_grant == 2'd2)});
    chk("i_rdata", i_rdata, v.exp_irdata);
    chk("d_rdata", d_rdata, v.exp_drdata);
    @(posedge clk); #1;
    chk("ready_drop", {30'd0, i_ready, d_ready}, 32'd0);
    chk("grant_idle", {30'd0, grant}, 32'd0);
  endtask

  initial begin
    logic [1:0] g;
    int wen_cnt;
    int rdy_cnt;
    vec_t v;

    //             ireq iaddr   dreq dwen daddr   dwdata        rdata         gnt  wen addr    wdata         i_rdata       d_rdata
    vecs[0] = '{1'b0, 12'h000, 1'b1, 1'b0, 12'h010, 32'h00000000, 32'h12345678, 2'd2, 1'b0, 12'h010, 32'h00000000, 32'h00000000, 32'h12345678};
    vecs[1] = '{1'b1, 12'h020, 1'b0, 1'b0, 12'h000, 32'h00000000, 32'hCAFEF00D, 2'd1, 1'b0, 12'h020, 32'h00000000, 32'hCAFEF00D, 32'h12345678};
    vecs[2] = '{1'b0, 12'h000, 1'b1, 1'b1, 12'h033, 32'hDEADBEEF, 32'h11111111, 2'd2, 1'b1, 12'h033, 32'hDEADBEEF, 32'hCAFEF00D, 32'h12345678};
    vecs[3] = '{1'b1, 12'h021, 1'b1, 1'b0, 12'h044, 32'h00000000, 32'h0BADF00D, 2'd2, 1'b0, 12'h044, 32'h00000000, 32'hCAFEF00D, 32'h0BADF00D};
    vecs[4] = '{1'b1, 12'h055, 1'b0, 1'b0, 12'h000, 32'h00000000, 32'h76543210, 2'd1, 1'b0, 12'h055, 32'h00000000, 32'h76543210, 32'h0BADF00D};

    nRST = 1'b0;
    i_req = 1'b0; d_req = 1'b0; d_wen = 1'b0; f_req = 1'b0; f_wen = 1'b0; ram_busy = 1'b0;
    i_addr = 12'h000; d_addr = 12'h000; f_addr = 12'h000;
    d_wdata = 32'h0; f_wdata = 32'h0; ram_rdata = 32'h0;
    #12;
    chk("rst_grant", {30'd0, grant}, 32'd0);
    chk("rst_readys", {28'd0, ram_wen, i_ready, d_ready, f_ready}, 32'd0);
    chk("rst_i_rdata", i_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_ram_addr", {20'd0, ram_addr}, 32'd0);
    chk("rst_ram_wdata", ram_wdata, 32'd0);
    @(negedge clk);
    nRST = 1'b1;
    @(posedge clk); #1;
    chk("idle_no_req_grant", {30'd0, grant}, 32'd0);

    for (int k = 0; k < 5; k++) run_vec(vecs[k]);

    // Starvation: i and d held, instruction must win the 5th arbitration.
    @(negedge clk);
    i_req = 1'b1; i_addr = 12'h0AA; d_req = 1'b1; d_wen = 1'b0; d_addr = 12'h0BB;
    ram_rdata = 32'h5A5A0000;
    for (int k = 1; k <= 5; k++) begin
      wait_grant(1'b1, g);
      chk($sformatf("starve_arb%0d", k), {30'd0, g}, (k == 5) ? 32'd1 : 32'd2);
      if (k == 5) begin
        i_req = 1'b0; d_req = 1'b0;
      end
      wait_grant(1'b0, g);
    end
    chk("starve_i_rdata", i_rdata, 32'h5A5A0000);

    // Seven busy cycles in WAIT stretch the response by exactly seven.
    @(negedge clk);
    d_req = 1'b1; d_wen = 1'b0; d_addr = 12'h066; ram_rdata = 32'h0A0B0C0D; ram_busy = 1'b1;
    @(posedge clk); #1;
    d_req = 1'b0;
    wen_cnt = (ram_wen === 1'b1) ? 1 : 0;
    for (int c = 1; c <= 9; c++) begin
      @(posedge clk); #1;
      if (ram_wen === 1'b1) wen_cnt++;
      chk($sformatf("busy_d_ready_c%0d", c), {31'd0, d_ready}, (c == 9) ? 32'd1 : 32'd0);
      if (c == 8) ram_busy = 1'b0;
    end
    chk("busy_wen_count", wen_cnt, 32'd0);
    chk("busy_d_rdata", d_rdata, 32'h0A0B0C0D);
    @(posedge clk); #1;

    // Reset during WAIT abandons the transfer without a ready pulse.
    @(negedge clk);
    d_req = 1'b1; d_wen = 1'b0; d_addr = 12'h077; ram_rdata = 32'h99999999; ram_busy = 1'b1;
    @(posedge clk); #1;
    d_req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_grant", {30'd0, grant}, 32'd2);
    @(negedge clk);
    nRST = 1'b0;
    #1;
    chk("mid_rst_grant", {30'd0, grant}, 32'd0);
    chk("mid_rst_d_rdata", d_rdata, 32'd0);
    @(negedge clk);
    nRST = 1'b1;
    ram_busy = 1'b0;
    rdy_cnt = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (d_ready === 1'b1 || grant !== 2'd0) rdy_cnt++;
    end
    chk("post_rst_quiet", rdy_cnt, 32'd0);
    v = '{1'b0, 12'h000, 1'b1, 1'b0, 12'h088, 32'h00000000, 32'h13572468, 2'd2, 1'b0, 12'h088, 32'h00000000, 32'h00000000, 32'h13572468};
    run_vec(v);

`ifdef MEM_ARBITER_FPGA_PORT_EN
    // All three requesters: FPGA write first, then data, then instruction.
    @(negedge clk);
    f_req = 1'b1; f_wen = 1'b1; f_addr = 12'h0FF; f_wdata = 32'hA5A5A5A5;
    d_req = 1'b1; d_wen = 1'b0; d_addr = 12'h011;
    i_req = 1'b1; i_addr = 12'h022;
    ram_busy = 1'b0;
    wait_grant(1'b1, g);
    chk("all3_first", {30'd0, g}, 32'd3);
    chk("all3_wen", {31'd0, ram_wen}, 32'd1);
    chk("all3_addr", {20'd0, ram_addr}, 32'h0FF);
    chk("all3_wdata", ram_wdata, 32'hA5A5A5A5);
    f_req = 1'b0;
    @(posedge clk); #1;
    chk("all3_wen_once", {31'd0, ram_wen}, 32'd0);
    @(posedge clk); #1;
    chk("all3_f_ready", {31'd0, f_ready}, 32'd1);
    wait_grant(1'b0, g);
    wait_grant(1'b1, g);
    chk("all3_second", {30'd0, g}, 32'd2);
    d_req = 1'b0;
    wait_grant(1'b0, g);
    wait_grant(1'b1, g);
    chk("all3_third", {30'd0, g}, 32'd1);
    i_req = 1'b0;
    wait_grant(1'b0, g);
`else
    // With the FPGA port compiled out, f_req alone must be ignored.
    @(negedge clk);
    f_req = 1'b1; f_wen = 1'b1; f_addr = 12'h0FF; f_wdata = 32'hA5A5A5A5;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      chk($sformatf("fdis_grant_c%0d", c), {30'd0, grant}, 32'd0);
      chk($sformatf("fdis_f_ready_c%0d", c), {28'd0, f_ready, ram_wen, 2'b00}, 32'd0);
    end
    f_req = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
